dmem_arbiter: RTL

Two-port arbiter that shares the single data memory between the processor core's load/store path and an external loader/debug port. It selects one requester per transaction, drives the memory's enable/write/address/data lines, holds the winner through the memory's read latency, and returns read data with a one-cycle valid pulse. It sits between the datapath's ALU-address/rs2-data outputs and the data memory, and supplies a stall signal that the PC register honours.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core load/store path and
// the loader/debug port. Grants are combinational in the request cycle; a read
// grant holds the memory for MEM_LAT cycles and returns data with a one-cycle
// rvalid pulse. Optional statistics counters are built when DMEM_ARB_STATS_EN
// is defined; otherwise the stat_* outputs are tied to zero.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_core_gnt,
  output logic [15:0]       stat_ldr_gnt,
  output logic [15:0]       stat_conflict
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t             state_q;
  logic               owner_ldr_q;
  logic               last_ldr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  c_rdata_q;
  logic [DATA_W-1:0]  l_rdata_q;

  logic               arb_en;
  logic               win_core;
  logic               win_ldr;
  logic               rd_done;

  // Arbitration: round-robin on conflict, loader keeps the slot while locked
  always_comb begin
    arb_en   = reset_n && (state_q == IDLE);
    win_core = 1'b0;
    win_ldr  = 1'b0;
    if (arb_en) begin
      if (c_req && l_req) begin
        win_core = last_ldr_q && !l_lock;
        win_ldr  = !win_core;
      end else begin
        win_core = c_req;
        win_ldr  = l_req;
      end
    end
  end

  // Memory command and grant outputs for the winning port
  always_comb begin
    c_gnt     = win_core;
    l_gnt     = win_ldr;
    mem_en    = win_core || win_ldr;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (win_core) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (win_ldr) begin
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  // Read return: data passes straight through in the rvalid cycle, then holds
  always_comb begin
    rd_done  = reset_n && (state_q == RD_WAIT) && (cnt_q == '0);
    c_rvalid = rd_done && !owner_ldr_q;
    l_rvalid = rd_done && owner_ldr_q;
    c_rdata  = c_rvalid ? mem_rdata : c_rdata_q;
    l_rdata  = l_rvalid ? mem_rdata : l_rdata_q;
    c_stall  = (c_req && !c_gnt) || ((state_q == RD_WAIT) && !owner_ldr_q);
  end

  // FSM: cnt_q counts the wait cycles still left before the data cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_ldr_q <= 1'b0;
      last_ldr_q  <= 1'b1;
      cnt_q       <= '0;
      c_rdata_q   <= '0;
      l_rdata_q   <= '0;
    end else begin
      if (c_rvalid) c_rdata_q <= mem_rdata;
      if (l_rvalid) l_rdata_q <= mem_rdata;
      case (state_q)
        IDLE: begin
          if (mem_en) begin
            last_ldr_q <= win_ldr;
            if (!mem_we) begin
              state_q     <= RD_WAIT;
              owner_ldr_q <= win_ldr;
              cnt_q       <= CNT_W'(MEM_LAT - 1);
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] core_cnt_q;
  logic [15:0] ldr_cnt_q;
  logic [15:0] conf_cnt_q;

  // Saturating grant and conflict counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_cnt_q <= '0;
      ldr_cnt_q  <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (c_gnt && (core_cnt_q != 16'hFFFF)) core_cnt_q <= core_cnt_q + 16'd1;
      if (l_gnt && (ldr_cnt_q != 16'hFFFF))  ldr_cnt_q  <= ldr_cnt_q + 16'd1;
      if (arb_en && c_req && l_req && (conf_cnt_q != 16'hFFFF))
        conf_cnt_q <= conf_cnt_q + 16'd1;
    end
  end

  assign stat_core_gnt = core_cnt_q;
  assign stat_ldr_gnt  = ldr_cnt_q;
  assign stat_conflict = conf_cnt_q;
`else
  assign stat_core_gnt = '0;
  assign stat_ldr_gnt  = '0;
  assign stat_conflict = '0;
`endif

endmodule
